moving_average_win: RTL



---
 rtl/moving_average_pkg.sv | 24 ++
 rtl/ma_ring_buffer.sv | 27 ++
 rtl/moving_average_win.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/moving_average_pkg.sv
// Shared types and helpers for the sliding-window averager.
// Optional feature macro: MOVING_AVERAGE_ROUND_EN (round-half-up plus output saturation).
package moving_average_pkg;

  localparam int DEFAULT_DATA_W   = 16;
  localparam int DEFAULT_MAX_LOG2 = 4;
  localparam int K_FIELD_W        = 8;

  typedef logic [K_FIELD_W-1:0] k_t;

  // Rounding needs one spare bit so the half-LSB addend cannot overflow the sum.
  function automatic int sum_w(input int data_w, input int max_log2);
`ifdef MOVING_AVERAGE_ROUND_EN
    return data_w + max_log2 + 1;
`else
    return data_w + max_log2;
`endif
  endfunction

  function automatic k_t clamp_k(input int k, input int max_log2);
    return (k > max_log2) ? k_t'(max_log2) : k_t'(k);
  endfunction

endpackage

// File: rtl/ma_ring_buffer.sv
// History store: one synchronous write port, one combinational read port.
// The read is asynchronous so the oldest sample is available in the accepting cycle.
module ma_ring_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/moving_average_win.sv
// Exact boxcar mean over a runtime-selectable 2^k window backed by a ring buffer.
// Optional feature macro: MOVING_AVERAGE_ROUND_EN (round-half-up plus output saturation).
module moving_average_win
  import moving_average_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int MAX_LOG2 = DEFAULT_MAX_LOG2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic                             clear,
  input  logic                             in_valid,
  input  logic signed [DATA_W-1:0]         din,
  input  logic [$clog2(MAX_LOG2+1)-1:0]    log2_len,
  input  logic                             decimate,
  output logic signed [DATA_W-1:0]         dout,
  output logic                             out_valid,
  output logic                             window_full
);

  localparam int SUM_W  = sum_w(DATA_W, MAX_LOG2);
  localparam int PTR_W  = MAX_LOG2;
  localparam int FILL_W = MAX_LOG2 + 1;

  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

  // Handshake: a sample is taken on any edge with enable & in_valid & ~clear;
  // there is no backpressure, and out_valid is a one-cycle pulse qualifying dout.

  logic signed [SUM_W-1:0]  r_sum;
  logic [FILL_W-1:0]        r_fill;
  logic [PTR_W-1:0]         r_phase;
  logic [PTR_W-1:0]         r_wr_ptr;
  k_t                       r_k;
  logic signed [DATA_W-1:0] r_dout;
  logic                     r_out_valid;
  logic                     r_window_full;

  k_t                       w_k;
  logic                     w_accept;
  logic                     w_restart;
  logic [FILL_W-1:0]        w_len;
  logic [PTR_W-1:0]         w_mask;
  logic [PTR_W-1:0]         w_rd_addr;
  logic [DATA_W-1:0]        w_old;
  logic signed [SUM_W-1:0]  w_din_ext;
  logic signed [SUM_W-1:0]  w_old_ext;
  logic signed [SUM_W-1:0]  w_base_sum;
  logic [FILL_W-1:0]        w_base_fill;
  logic [PTR_W-1:0]         w_base_phase;
  logic signed [SUM_W-1:0]  w_sum_next;
  logic [FILL_W-1:0]        w_fill_next;
  logic [PTR_W-1:0]         w_phase_next;
  logic                     w_now_full;
  logic                     w_fire;
  logic signed [DATA_W-1:0] w_avg;

  assign w_k       = clamp_k(int'(log2_len), MAX_LOG2);
  assign w_accept  = enable & in_valid & ~clear;
  assign w_restart = (w_k != r_k);
  assign w_len     = FILL_ONE << w_k;
  assign w_mask    = PTR_W'(w_len - FILL_ONE);
  // For the deepest window this lands on wr_ptr itself, read before it is overwritten.
  assign w_rd_addr = r_wr_ptr - PTR_W'(w_len);

  ma_ring_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (PTR_W)
  ) u_ring (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_wr_ptr),
    .i_wdata (din),
    .i_raddr (w_rd_addr),
    .o_rdata (w_old)
  );

  assign w_din_ext = {{(SUM_W-DATA_W){din[DATA_W-1]}}, din};
  assign w_old_ext = {{(SUM_W-DATA_W){w_old[DATA_W-1]}}, w_old};

  // A window change behaves like an empty history: the new sample starts the sum.
  always_comb begin
    w_base_sum   = r_sum;
    w_base_fill  = r_fill;
    w_base_phase = r_phase;
    if (w_restart) begin
      w_base_sum   = '0;
      w_base_fill  = '0;
      w_base_phase = '0;
    end

    w_sum_next  = w_base_sum + w_din_ext;
    w_fill_next = w_base_fill + FILL_ONE;
    if (w_base_fill >= w_len) begin
      w_sum_next  = w_base_sum + w_din_ext - w_old_ext;
      w_fill_next = w_base_fill;
    end

    w_now_full   = (w_fill_next == w_len);
    w_fire       = w_now_full && (!decimate || (w_base_phase == '0));
    w_phase_next = '0;
    if (w_now_full) begin
      w_phase_next = (w_base_phase + PTR_ONE) & w_mask;
    end
  end

`ifdef MOVING_AVERAGE_ROUND_EN
  localparam logic signed [SUM_W-1:0] SUM_ONE = SUM_W'(1);

  logic signed [SUM_W-1:0] w_round_add;
  logic signed [SUM_W-1:0] w_shifted;
  logic                    w_ovf;

  always_comb begin
    w_round_add = '0;
    if (w_k != '0) begin
      w_round_add = SUM_ONE <<< (w_k - k_t'(1));
    end
    w_shifted = (w_sum_next + w_round_add) >>> w_k;
    w_ovf     = !((&w_shifted[SUM_W-1:DATA_W-1]) || !(|w_shifted[SUM_W-1:DATA_W-1]));
    w_avg     = w_shifted[DATA_W-1:0];
    if (w_ovf) begin
      w_avg = w_shifted[SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                 : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  always_comb begin
    w_avg = DATA_W'(w_sum_next >>> w_k);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum         <= '0;
      r_fill        <= '0;
      r_phase       <= '0;
      r_wr_ptr      <= '0;
      r_k           <= '0;
      r_dout        <= '0;
      r_out_valid   <= 1'b0;
      r_window_full <= 1'b0;
    end else if (enable) begin
      r_out_valid <= 1'b0;
      if (clear) begin
        r_sum         <= '0;
        r_fill        <= '0;
        r_phase       <= '0;
        r_window_full <= 1'b0;
      end else if (in_valid) begin
        r_sum         <= w_sum_next;
        r_fill        <= w_fill_next;
        r_phase       <= w_phase_next;
        r_wr_ptr      <= r_wr_ptr + PTR_ONE;
        r_k           <= w_k;
        r_window_full <= w_now_full;
        if (w_fire) begin
          r_dout      <= w_avg;
          r_out_valid <= 1'b1;
        end
      end
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign dout        = r_dout;
  assign out_valid   = r_out_valid;
  assign window_full = r_window_full;

endmodule
